// File: rtl/uart_tx_fifo_param_if.sv
// Valid/ready write port of the UART transmitter FIFO.
// The master side offers words and the slave side signals space available.
interface uart_tx_fifo_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with a TX FIFO.
// Frames are start, DATA_BITS LSB first, optional parity and STOP_BITS stop bits, sent back to back.
module uart_tx_fifo_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    uart_tx_fifo_param_if.slave               tx_if,
    input  logic [DIV_W-1:0]                  baud_div,
    output logic                              txd,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    state_t               state_reg, state_next;
    logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [DIV_W-1:0]     div_reg, div_next;
    logic [DIV_W-1:0]     baud_cnt_reg, baud_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic                 txd_reg, txd_next;

    logic push;
    logic pop;
    logic bit_end;
    logic have_word;

    assign tx_if.tx_ready = (count_reg != CNT_W'(FIFO_DEPTH));
    assign push           = tx_if.tx_valid && tx_if.tx_ready;
    assign bit_end        = (baud_cnt_reg == '0);
    assign have_word      = (count_reg != '0);

    assign txd        = txd_reg;
    assign busy       = (state_reg != S_IDLE) || have_word;
    assign fifo_count = count_reg;

    // FIFO storage has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_if.tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            div_reg      <= '0;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            txd_reg      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            div_reg      <= div_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            txd_reg      <= txd_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rd_ptr_next   = rd_ptr_reg;
        div_next      = div_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        pop           = 1'b0;

        if (state_reg != S_IDLE) begin
            baud_cnt_next = bit_end ? div_reg : baud_cnt_reg - 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                pop = have_word;
            end
            S_START: begin
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_reg == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        shift_next   = shift_reg >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_reg == BIT_W'(STOP_BITS - 1)) begin
                        bit_cnt_next = '0;
                        pop          = have_word;
                        state_next   = S_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Loading a word restarts the frame; the divisor is frozen until the next load.
        if (pop) begin
            state_next    = S_START;
            shift_next    = mem[rd_ptr_reg];
            parity_next   = (^mem[rd_ptr_reg]) ^ (PARITY == 2);
            div_next      = baud_div;
            baud_cnt_next = baud_div;
            bit_cnt_next  = '0;
            rd_ptr_next   = rd_ptr_reg + 1'b1;
        end
    end

    always_comb begin
        wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // txd is registered from the upcoming state so the line changes on the same edge as the state.
    always_comb begin
        case (state_next)
            S_START:  txd_next = 1'b0;
            S_DATA:   txd_next = shift_next[0];
            S_PARITY: txd_next = parity_next;
            default:  txd_next = 1'b1;
        endcase
    end
endmodule
